// File: rtl/icache_fill_ctrl_pkg.sv
// rtl/icache_fill_ctrl_pkg.sv - shared constants, state encoding and helpers for the fill controller
package icache_fill_ctrl_pkg;

   localparam int WORDS_PER_BLOCK = 8;
   localparam int ADDR_W          = 16;
   localparam int DATA_W          = 16;
   localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK);
   localparam int CNT_W           = OFFSET_W + 1;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   // Clear the in-block byte offset (words are two bytes wide).
   function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
   endfunction

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// rtl/icache_fill_ctrl_if.sv - cache/memory side signal bundle of the fill controller
interface icache_fill_ctrl_if;
   import icache_fill_ctrl_pkg::*;

   logic                miss_detected;
   logic [ADDR_W-1:0]   miss_address;
   logic [DATA_W-1:0]   memory_data;
   logic                memory_data_valid;
   logic                fsm_busy;
   logic                mem_read_en;
   logic [ADDR_W-1:0]   memory_address;
   logic                write_data_array;
   logic                write_tag_array;
   logic [OFFSET_W-1:0] word_offset;
   logic [DATA_W-1:0]   cache_data;
   logic                fill_done;

   // Controller side.
   modport master (
      input  miss_detected, miss_address, memory_data, memory_data_valid,
      output fsm_busy, mem_read_en, memory_address, write_data_array,
             write_tag_array, word_offset, cache_data, fill_done
   );

   // Cache/memory side.
   modport slave (
      output miss_detected, miss_address, memory_data, memory_data_valid,
      input  fsm_busy, mem_read_en, memory_address, write_data_array,
             write_tag_array, word_offset, cache_data, fill_done
   );

endinterface

// File: rtl/icache_fill_ctrl_fill_counter.sv
// rtl/icache_fill_ctrl_fill_counter.sv - word counter with sync clear, enable and terminal count
module icache_fill_ctrl_fill_counter
   import icache_fill_ctrl_pkg::*;
#(
   parameter int TC = WORDS_PER_BLOCK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear wins over enable so a new fill always starts from word zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == CNT_W'(TC));

endmodule

// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - cache miss block-fill controller with pipelined memory reads
module icache_fill_ctrl
   import icache_fill_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   icache_fill_ctrl_if.master bus
);

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] base_d;

   logic [CNT_W-1:0]  issue_cnt;
   logic [CNT_W-1:0]  recv_cnt;
   logic              issue_tc;
   logic              recv_last;

   logic              start_fill;
   logic              issue_en;
   logic              recv_en;
   logic              last_word;

   assign start_fill = (state_q == IDLE) && bus.miss_detected;
   assign issue_en   = (state_q == FILL) && !issue_tc;
   // Returns outside FILL (late data after an abort) are dropped here.
   assign recv_en    = (state_q == FILL) && bus.memory_data_valid;
   assign last_word  = recv_en && recv_last;

   // Issue side: terminal count stops requests after the last word.
   icache_fill_ctrl_fill_counter #(.TC(WORDS_PER_BLOCK)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (start_fill),
      .en_i  (issue_en),
      .cnt_o (issue_cnt),
      .tc_o  (issue_tc)
   );

   // Receive side: terminal count flags the final word of the block.
   icache_fill_ctrl_fill_counter #(.TC(WORDS_PER_BLOCK - 1)) u_recv_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (start_fill),
      .en_i  (recv_en),
      .cnt_o (recv_cnt),
      .tc_o  (recv_last)
   );

   // Next state: a miss is only accepted in IDLE; a fill ends on its last return.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      case (state_q)
         IDLE: begin
            if (bus.miss_detected) begin
               state_d = FILL;
               base_d  = block_base(bus.miss_address);
            end
         end
         FILL: begin
            if (last_word) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and block-base registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
      end
   end

   // Busy covers the miss cycle itself so the pipeline never advances past it.
   assign bus.fsm_busy         = (state_q == FILL) || bus.miss_detected;
   assign bus.mem_read_en      = issue_en;
   assign bus.memory_address   = base_q + ADDR_W'({issue_cnt, 1'b0});
   assign bus.write_data_array = recv_en;
   assign bus.write_tag_array  = last_word;
   assign bus.fill_done        = last_word;
   assign bus.word_offset      = recv_cnt[OFFSET_W-1:0];
   assign bus.cache_data       = bus.memory_data;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb/tb_icache_fill_ctrl.sv - self-checking bench for icache_fill_ctrl with a 4-cycle memory model
module tb_icache_fill_ctrl;

   typedef struct {
      logic [15:0] miss_addr;
      logic [15:0] exp_base;
      logic        hold_miss;
      logic        gap_after;
   } vec_t;

   typedef struct {
      int          due;
      logic [15:0] addr;
   } mreq_t;

   typedef struct {
      logic [2:0]  off;
      logic [15:0] data;
   } ew_t;

   logic clk;
   logic rst;

   icache_fill_ctrl_if bus ();

   icache_fill_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int tag_cnt = 0;
   int issue_idx = 0;
   logic [15:0] cur_base;

   mreq_t mq[$];
   ew_t   eq[$];

   logic        s_busy, s_rd, s_wr, s_tag, s_done;
   logic [15:0] s_addr, s_data;
   logic [2:0]  s_off;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive memory returns, sample outputs, update model, advance.
   task automatic tick();
      ew_t e;
      if (mq.size() > 0 && mq[0].due == cyc) begin
         bus.memory_data_valid = 1'b1;
         bus.memory_data       = mq[0].addr ^ 16'hA5A5;
         void'(mq.pop_front());
      end else begin
         bus.memory_data_valid = 1'b0;
         bus.memory_data       = 16'($urandom);
      end
      #1;
      s_busy = bus.fsm_busy;
      s_rd   = bus.mem_read_en;
      s_addr = bus.memory_address;
      s_wr   = bus.write_data_array;
      s_tag  = bus.write_tag_array;
      s_done = bus.fill_done;
      s_off  = bus.word_offset;
      s_data = bus.cache_data;
      if (s_wr) begin
         if (eq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=off%0d required=no_write (cycle %0d)", s_off, cyc);
         end else begin
            e = eq.pop_front();
            chk("write_offset", 32'(s_off), 32'(e.off));
            chk("write_data", 32'(s_data), 32'(e.data));
         end
      end
      if (s_rd) begin
         mq.push_back('{cyc + 4, s_addr});
         eq.push_back('{3'(issue_idx), (cur_base + 16'(2 * issue_idx)) ^ 16'hA5A5});
         issue_idx++;
      end
      if (s_tag) tag_cnt++;
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_fill(input vec_t v);
      int  t0;
      int  pre;
      bit  done;
      cur_base  = v.exp_base;
      issue_idx = 0;
      t0        = tag_cnt;
      bus.miss_detected = 1'b1;
      bus.miss_address  = v.miss_addr;
      tick();
      chk("busy_miss_cycle", 32'(s_busy), 32'd1);
      chk("no_read_miss_cycle", 32'(s_rd), 32'd0);
      bus.miss_detected = v.hold_miss;
      done = 1'b0;
      for (int c = 1; c <= 30 && !done; c++) begin
         pre = issue_idx;
         tick();
         chk("busy_fill", 32'(s_busy), 32'd1);
         if (s_rd) chk("req_addr", 32'(s_addr), 32'(cur_base + 16'(2 * pre)));
         if (s_done) begin
            done = 1'b1;
            chk("done_cycle", 32'(c), 32'd12);
            chk("tag_with_done", 32'(s_tag), 32'd1);
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL fill_timeout actual=no_fill_done required=fill_done base=%h", v.exp_base);
      end
      chk("req_count", 32'(issue_idx), 32'd8);
      chk("tag_count", 32'(tag_cnt - t0), 32'd1);
      chk("scoreboard_empty", 32'(eq.size()), 32'd0);
      bus.miss_detected = 1'b0;
      if (v.gap_after) begin
         tick();
         chk("idle_after_fill", 32'(s_busy), 32'd0);
         chk("no_read_after_fill", 32'(s_rd), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{16'h1236, 16'h1230, 1'b0, 1'b1};
      vecs[1] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[2] = '{16'h0040, 16'h0040, 1'b0, 1'b1};
      vecs[3] = '{16'h0057, 16'h0050, 1'b1, 1'b1};
      vecs[4] = '{16'hFFFA, 16'hFFF0, 1'b0, 1'b1};

      rst = 1'b1;
      bus.miss_detected     = 1'b0;
      bus.miss_address      = 16'h0;
      bus.memory_data       = 16'h0;
      bus.memory_data_valid = 1'b0;
      cur_base = 16'h0;
      @(negedge clk);
      tick();
      tick();
      chk("reset_busy", 32'(s_busy), 32'd0);
      chk("reset_read", 32'(s_rd), 32'd0);
      chk("reset_wr", 32'(s_wr), 32'd0);
      chk("reset_tag", 32'(s_tag), 32'd0);
      chk("reset_done", 32'(s_done), 32'd0);
      rst = 1'b0;
      tick();

      // Stray return while idle: no array write, no state change.
      mq.push_back('{cyc, 16'h1111});
      tick();
      chk("stray_valid_wr", 32'(s_wr), 32'd0);
      chk("stray_valid_busy", 32'(s_busy), 32'd0);
      tick();
      chk("stray_valid_after", 32'(s_busy), 32'd0);

      for (int i = 0; i < 5; i++) run_fill(vecs[i]);

      // Reset in cycle 6 of a fill aborts it; late returns are dropped.
      begin
         int t0;
         t0        = tag_cnt;
         cur_base  = 16'h3000;
         issue_idx = 0;
         bus.miss_detected = 1'b1;
         bus.miss_address  = 16'h3004;
         tick();
         bus.miss_detected = 1'b0;
         for (int c = 1; c <= 5; c++) tick();
         rst = 1'b1;
         tick();
         rst = 1'b0;
         eq.delete();
         for (int c = 7; c <= 11; c++) begin
            tick();
            chk("abort_busy", 32'(s_busy), 32'd0);
            chk("abort_wr", 32'(s_wr), 32'd0);
            chk("abort_rd", 32'(s_rd), 32'd0);
         end
         chk("abort_no_tag", 32'(tag_cnt - t0), 32'd0);
         chk("abort_mem_drained", 32'(mq.size()), 32'd0);
      end
      run_fill('{16'h2000, 16'h2000, 1'b0, 1'b1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
